amo_responder: RTL and testbench

AMO_RESPONDER -- requirements
Module: amo_responder

---
 rtl/amo_responder_if.sv | 28 ++
 rtl/amo_responder.sv | 173 +++++++++++++++++
 tb/tb_amo_responder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/amo_responder_if.sv
// Bus bundle between a requester, the AMO responder and a single-port word memory.
// Handshakes: a request transfers on a cycle where req_valid_i & req_ready_o; a response transfers
// on a cycle where rsp_valid_o & rsp_ready_i; a raised valid and its payload hold until the transfer.
interface amo_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  req_op_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_data_i;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;

  modport slave (
    input  req_valid_i, req_op_i, req_addr_i, req_data_i, mem_data_i, rsp_ready_i,
    output req_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_data_o, rsp_valid_o, rsp_data_o
  );

  modport master (
    output req_valid_i, req_op_i, req_addr_i, req_data_i, mem_data_i, rsp_ready_i,
    input  req_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_data_o, rsp_valid_o, rsp_data_o
  );
endinterface

// File: rtl/amo_responder.sv
// Atomic memory operation responder: read-modify-write AMOs plus LR/SC with a single reservation.
// One request in flight; the FSM state is exported on dbg_state.
module amo_responder #(
  parameter int RESV_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  amo_responder_if.slave   bus,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WAIT   = 3'd2,
    S_MODIFY = 3'd3,
    S_WRITE  = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  localparam logic [3:0] OP_LR   = 4'd0;
  localparam logic [3:0] OP_SC   = 4'd1;
  localparam logic [3:0] OP_SWAP = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_MIN  = 4'd7;
  localparam logic [3:0] OP_MAX  = 4'd8;
  localparam logic [3:0] OP_MINU = 4'd9;
  localparam logic [3:0] OP_MAXU = 4'd10;

  localparam bit RESV = (RESV_EN != 0);

  state_e      state_q, state_d;
  logic [3:0]  op_q;
  logic [29:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] old_q;
  logic [31:0] result_q;
  logic [31:0] rsp_q;
  logic        resv_valid;
  logic [29:0] resv_addr;

  logic        accept;
  logic        req_is_sc;
  logic        sc_hit;
  logic        op_legal;
  logic [31:0] amo_res;

  logic        req_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  logic        unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, bus.req_addr_i[1:0]};

  assign accept    = bus.req_valid_i && (state_q == S_IDLE);
  assign req_is_sc = (bus.req_op_i == OP_SC);
  assign sc_hit    = RESV && resv_valid && (resv_addr == bus.req_addr_i[31:2]);
  assign op_legal  = (op_q <= OP_MAXU);
  assign dbg_state = state_q;

  // Ties on MIN/MAX keep the memory value.
  always_comb begin
    amo_res = old_q;
    case (op_q)
      OP_SWAP: amo_res = data_q;
      OP_ADD:  amo_res = old_q + data_q;
      OP_XOR:  amo_res = old_q ^ data_q;
      OP_AND:  amo_res = old_q & data_q;
      OP_OR:   amo_res = old_q | data_q;
      OP_MIN:  amo_res = ($signed(data_q) < $signed(old_q)) ? data_q : old_q;
      OP_MAX:  amo_res = ($signed(data_q) > $signed(old_q)) ? data_q : old_q;
      OP_MINU: amo_res = (data_q < old_q) ? data_q : old_q;
      OP_MAXU: amo_res = (data_q > old_q) ? data_q : old_q;
      default: amo_res = old_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 32'd0;
    rsp_valid = 1'b0;
    rsp_data  = 32'd0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (req_is_sc) state_d = sc_hit ? S_WRITE : S_RESP;
          else           state_d = S_READ;
        end
      end
      S_READ: begin
        mem_en  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT:   state_d = S_MODIFY;
      S_MODIFY: state_d = ((op_q == OP_LR) || !op_legal) ? S_RESP : S_WRITE;
      S_WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = (op_q == OP_SC) ? data_q : result_q;
        state_d   = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = rsp_q;
        if (bus.rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, including the IDLE ready.
  always_comb begin
    bus.req_ready_o = req_ready && !reset;
    bus.mem_en_o    = mem_en && !reset;
    bus.mem_we_o    = mem_we && !reset;
    bus.mem_addr_o  = reset ? 32'd0 : {addr_q, 2'b00};
    bus.mem_data_o  = reset ? 32'd0 : mem_wdata;
    bus.rsp_valid_o = rsp_valid && !reset;
    bus.rsp_data_o  = reset ? 32'd0 : rsp_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 4'd0;
      addr_q     <= 30'd0;
      data_q     <= 32'd0;
      old_q      <= 32'd0;
      result_q   <= 32'd0;
      rsp_q      <= 32'd0;
      resv_valid <= 1'b0;
      resv_addr  <= 30'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= bus.req_op_i;
        addr_q <= bus.req_addr_i[31:2];
        data_q <= bus.req_data_i;
        if (req_is_sc) begin
          resv_valid <= 1'b0;
          rsp_q      <= sc_hit ? 32'd0 : 32'd1;
        end
      end
      case (state_q)
        S_WAIT: old_q <= bus.mem_data_i;
        S_MODIFY: begin
          result_q <= amo_res;
          rsp_q    <= old_q;
          if (RESV && (op_q == OP_LR)) begin
            resv_valid <= 1'b1;
            resv_addr  <= addr_q;
          end
        end
        // A store from another AMO to the reserved word breaks the reservation.
        S_WRITE: begin
          if ((op_q != OP_SC) && (resv_addr == addr_q)) resv_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_amo_responder.sv
// Directed bench for amo_responder: a word memory model answers the read/write strobes and
// each request is traced cycle by cycle against hand-computed values.
module tb_amo_responder;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;

  amo_responder_if bus ();

  amo_responder #(.RESV_EN(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: read data appears the cycle after the read strobe
  logic [31:0] mem [0:255];
  logic        poke_en;
  logic [7:0]  poke_idx;
  logic [31:0] poke_val;
  int          wr_total;

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (bus.mem_en_o && bus.mem_we_o) mem[bus.mem_addr_o[9:2]] <= bus.mem_data_o;
    if (bus.mem_en_o && !bus.mem_we_o) bus.mem_data_i <= mem[bus.mem_addr_o[9:2]];
  end

  initial wr_total = 0;
  always @(negedge clk) begin
    if (bus.mem_en_o && bus.mem_we_o) wr_total <= wr_total + 1;
  end

  // scoreboard counters
  int n_cmp;
  int n_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // per-request trace
  int          r_rd_c, r_wr_c, r_rsp_c, r_n_rd, r_n_wr, r_n_rsp, r_hold_bad;
  logic [31:0] r_wr_d, r_rsp_d;

  task automatic poke(input logic [31:0] addr, input logic [31:0] val);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = addr[9:2];
    poke_val = val;
    @(negedge clk);
    poke_en  = 1'b0;
  endtask

  task automatic run_req(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input int stall);
    int cyc;
    int left;
    bit done;
    r_rd_c = -1; r_wr_c = -1; r_rsp_c = -1;
    r_n_rd = 0; r_n_wr = 0; r_n_rsp = 0; r_hold_bad = 0;
    r_wr_d = 32'd0; r_rsp_d = 32'd0;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_addr_i  = addr;
    bus.req_data_i  = data;
    bus.rsp_ready_i = (stall == 0);
    @(posedge clk);
    cyc  = 1;
    left = stall;
    done = 1'b0;
    while (!done && cyc <= 40) begin
      @(negedge clk);
      if (cyc == 1) bus.req_valid_i = 1'b0;
      if (bus.mem_en_o && !bus.mem_we_o) begin r_n_rd++; r_rd_c = cyc; end
      if (bus.mem_en_o && bus.mem_we_o) begin r_n_wr++; r_wr_c = cyc; r_wr_d = bus.mem_data_o; end
      if (bus.rsp_valid_o) begin
        r_n_rsp++;
        if (r_rsp_c < 0) begin
          r_rsp_c = cyc;
          r_rsp_d = bus.rsp_data_o;
        end else if (bus.rsp_data_o !== r_rsp_d || bus.req_ready_o || bus.mem_en_o) begin
          r_hold_bad++;
        end
        if (left > 0) left--;
        if (left == 0) begin
          bus.rsp_ready_i = 1'b1;
          done = 1'b1;
        end
      end
      if (!done) begin
        @(posedge clk);
        cyc++;
      end
    end
    check_eq("rsp_seen", 32'(done), 32'd1);
  endtask

  logic [3:0]  t_op  [9] = '{4'd4, 4'd5, 4'd6, 4'd2, 4'd8, 4'd10, 4'd3, 4'd7, 4'd8};
  logic [31:0] t_dat [9] = '{32'hFF, 32'h3C, 32'h0F, 32'h1234, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FF20, 32'hF0, 32'h8000_0000};
  logic [31:0] t_exp [9] = '{32'h0F, 32'h30, 32'hFF, 32'h1234, 32'hF0, 32'hFFFF_FFFF,
                             32'h10, 32'hF0, 32'hF0};

  initial begin
    bit hit;
    int wr_before;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    poke_en = 1'b0; poke_idx = 8'd0; poke_val = 32'd0;
    bus.req_valid_i = 1'b0; bus.req_op_i = 4'd0; bus.req_addr_i = 32'd0;
    bus.req_data_i = 32'd0; bus.rsp_ready_i = 1'b1; bus.mem_data_i = 32'd0;

    // outputs held low during reset
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
    check_eq("rst_mem_en", 32'(bus.mem_en_o), 32'd0);
    check_eq("rst_mem_we", 32'(bus.mem_we_o), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check_eq("rst_mem_addr", bus.mem_addr_o, 32'd0);
    check_eq("rst_mem_data", bus.mem_data_o, 32'd0);
    check_eq("rst_rsp_data", bus.rsp_data_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("post_rst_ready", 32'(bus.req_ready_o), 32'd1);
    check_eq("post_rst_state", 32'(dbg_state), 32'd0);

    poke(32'h40, 32'd5);
    poke(32'h10, 32'hFFFF_FFFF);
    poke(32'h80, 32'd7);
    poke(32'h84, 32'd0);

    // ADD latency and result
    run_req(4'd3, 32'h40, 32'd3, 0);
    check_eq("add_rd_cyc", r_rd_c, 32'd1);
    check_eq("add_wr_cyc", r_wr_c, 32'd4);
    check_eq("add_wr_data", r_wr_d, 32'd8);
    check_eq("add_rsp_cyc", r_rsp_c, 32'd5);
    check_eq("add_rsp_data", r_rsp_d, 32'd5);
    check_eq("add_n_rd", r_n_rd, 32'd1);
    check_eq("add_n_wr", r_n_wr, 32'd1);
    check_eq("add_mem", mem[8'h10], 32'd8);

    // signed vs unsigned minimum
    run_req(4'd7, 32'h10, 32'd1, 0);
    check_eq("min_wr", r_wr_d, 32'hFFFF_FFFF);
    check_eq("min_rsp", r_rsp_d, 32'hFFFF_FFFF);
    run_req(4'd9, 32'h10, 32'd1, 0);
    check_eq("minu_wr", r_wr_d, 32'd1);
    check_eq("minu_rsp", r_rsp_d, 32'hFFFF_FFFF);
    check_eq("minu_mem", mem[8'h04], 32'd1);

    // remaining AMO ops against 0xF0
    for (int i = 0; i < 9; i++) begin
      poke(32'h20, 32'hF0);
      run_req(t_op[i], 32'h20, t_dat[i], 0);
      check_eq($sformatf("amo%0d_wr", i), r_wr_d, t_exp[i]);
      check_eq($sformatf("amo%0d_rsp", i), r_rsp_d, 32'hF0);
    end

    // LR / SC success / repeated SC
    run_req(4'd0, 32'h80, 32'd0, 0);
    check_eq("lr_rsp", r_rsp_d, 32'd7);
    check_eq("lr_rsp_cyc", r_rsp_c, 32'd4);
    check_eq("lr_n_wr", r_n_wr, 32'd0);
    run_req(4'd1, 32'h80, 32'd9, 0);
    check_eq("sc_ok_wr_cyc", r_wr_c, 32'd1);
    check_eq("sc_ok_wr", r_wr_d, 32'd9);
    check_eq("sc_ok_rsp_cyc", r_rsp_c, 32'd2);
    check_eq("sc_ok_rsp", r_rsp_d, 32'd0);
    check_eq("sc_ok_n_rd", r_n_rd, 32'd0);
    run_req(4'd1, 32'h80, 32'd9, 0);
    check_eq("sc_again_n_wr", r_n_wr, 32'd0);
    check_eq("sc_again_rsp_cyc", r_rsp_c, 32'd1);
    check_eq("sc_again_rsp", r_rsp_d, 32'd1);

    // intervening AMO write to the reserved word breaks it; to another word it does not
    run_req(4'd0, 32'h80, 32'd0, 0);
    run_req(4'd2, 32'h80, 32'd2, 0);
    run_req(4'd1, 32'h80, 32'd7, 0);
    check_eq("sc_broken_rsp", r_rsp_d, 32'd1);
    check_eq("sc_broken_mem", mem[8'h20], 32'd2);
    run_req(4'd0, 32'h80, 32'd0, 0);
    check_eq("lr2_rsp", r_rsp_d, 32'd2);
    run_req(4'd2, 32'h84, 32'd3, 0);
    run_req(4'd1, 32'h80, 32'd11, 0);
    check_eq("sc_kept_rsp", r_rsp_d, 32'd0);
    check_eq("sc_kept_mem", mem[8'h20], 32'd11);

    // an LR to another word replaces the reservation
    run_req(4'd0, 32'h80, 32'd0, 0);
    run_req(4'd0, 32'h84, 32'd0, 0);
    check_eq("lr84_rsp", r_rsp_d, 32'd3);
    run_req(4'd1, 32'h80, 32'd5, 0);
    check_eq("sc_replaced_rsp", r_rsp_d, 32'd1);
    check_eq("sc_replaced_n_wr", r_n_wr, 32'd0);

    // illegal ops: no write, old value back
    run_req(4'd12, 32'h40, 32'd99, 0);
    check_eq("ill12_n_wr", r_n_wr, 32'd0);
    check_eq("ill12_rsp", r_rsp_d, 32'd8);
    check_eq("ill12_rsp_cyc", r_rsp_c, 32'd4);
    run_req(4'd15, 32'h40, 32'd99, 0);
    check_eq("ill15_n_wr", r_n_wr, 32'd0);
    check_eq("ill15_mem", mem[8'h10], 32'd8);

    // response stall for 10 cycles
    run_req(4'd3, 32'h40, 32'd2, 10);
    check_eq("stall_rsp", r_rsp_d, 32'd8);
    check_eq("stall_n_rsp", r_n_rsp, 32'd10);
    check_eq("stall_hold_bad", r_hold_bad, 32'd0);
    check_eq("stall_n_wr", r_n_wr, 32'd1);
    check_eq("stall_mem", mem[8'h10], 32'd10);

    // reset during MODIFY kills the pending write and the reservation
    run_req(4'd0, 32'h80, 32'd0, 0);
    check_eq("lr3_rsp", r_rsp_d, 32'd11);
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = 4'd3;
    bus.req_addr_i  = 32'h40;
    bus.req_data_i  = 32'd1;
    @(posedge clk);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      if (dbg_state == 3'd3) hit = 1'b1;
    end
    check_eq("reach_modify", 32'(hit), 32'd1);
    wr_before = wr_total;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_state", 32'(dbg_state), 32'd0);
    check_eq("mid_rst_ready", 32'(bus.req_ready_o), 32'd0);
    check_eq("mid_rst_mem_en", 32'(bus.mem_en_o), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rel_ready", 32'(bus.req_ready_o), 32'd1);
    repeat (6) @(negedge clk);
    check_eq("no_late_write", wr_total, wr_before);
    check_eq("no_late_mem", mem[8'h10], 32'd10);
    run_req(4'd1, 32'h80, 32'd5, 0);
    check_eq("sc_after_rst_rsp", r_rsp_d, 32'd1);
    check_eq("sc_after_rst_n_wr", r_n_wr, 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
